// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: the buffered entry layout,
// the default depth, and the pointer-width function.
package store_buffer_pkg;

  localparam int SB_DEFAULT_DEPTH = 4;
  localparam int SB_AW            = 32;
  localparam int SB_DW            = 32;

  // One buffered store; field widths set the AW/DW the buffer is built with.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Width of a head/tail pointer for a power-of-two depth.
  function automatic int sb_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// Youngest-match selection for load forwarding. Walks the ring from the head
// (oldest) towards the tail; a later match overrides an earlier one, so the
// surviving index is the youngest matching entry.
module sb_fwd_select #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int PW    = 2
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PW-1:0]    head,
  input  logic [DW-1:0]    data [DEPTH],
  output logic             hit,
  output logic [DW-1:0]    hit_data
);

  logic          any_hit;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;

  // Scan oldest to youngest; the last match seen wins.
  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (match[idx]) begin
        any_hit = 1'b1;
        sel     = idx;
      end
    end
  end

  assign hit      = any_hit;
  assign hit_data = any_hit ? data[sel] : '0;

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the pipeline and the data-memory write port.
// Stores are queued as {addr, data}; the head entry drains whenever the write
// port is free. Optional load forwarding is built when STORE_BUFFER_FWD_EN
// is defined; otherwise ld_hit/ld_data are tied low.
//
// Handshake: a store is accepted on a rising edge exactly when st_valid and
// st_ready are both high; st_ready depends only on occupancy (never on drain
// in the same cycle), and a store offered while full is dropped without any
// state change.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEFAULT_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  output logic                   st_ready,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic [DW-1:0]          ld_data,
  input  logic                   drain_en,
  output logic                   MemWr,
  output logic [AW-1:0]          dm_addr,
  output logic [DW-1:0]          dm_in,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            PW         = sb_ptr_w(DEPTH);
  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] valid_q;
  sb_entry_t        entry_q [DEPTH];

  logic push;
  logic pop;

  // Occupancy alone decides acceptance; a store into an empty buffer is not
  // visible at the write port until the following cycle.
  assign st_ready = (count_q < FULL_COUNT);
  assign push     = st_valid && st_ready;
  assign pop      = drain_en && (count_q != '0);

  assign MemWr    = pop;
  assign dm_addr  = entry_q[head_q].addr;
  assign dm_in    = entry_q[head_q].data;
  assign count    = count_q;

  // Head/tail pointers and occupancy; power-of-two depth lets pointers wrap
  // naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Per-entry valid bits; push and pop never target the same slot because a
  // push needs a free slot and a pop needs an occupied one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (pop)  valid_q[head_q] <= 1'b0;
      if (push) valid_q[tail_q] <= 1'b1;
    end
  end

  // Entry payload storage; contents are left as-is across reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[tail_q].addr <= st_addr;
      entry_q[tail_q].data <= st_data;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH-1:0] match;
  logic [DW-1:0]    data_arr [DEPTH];
  logic             unused_ld_offset;

  // Word-address comparison against every valid entry; the byte offset is
  // ignored, and the store being pushed this cycle is not yet valid.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign match[g]    = valid_q[g] && (entry_q[g].addr[AW-1:2] == ld_addr[AW-1:2]);
    assign data_arr[g] = entry_q[g].data;
  end

  assign unused_ld_offset = ^ld_addr[1:0];

  sb_fwd_select #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd_select (
    .match    (match),
    .head     (head_q),
    .data     (data_arr),
    .hit      (ld_hit),
    .hit_data (ld_data)
  );
`else
  logic unused_fwd;

  assign ld_hit     = 1'b0;
  assign ld_data    = '0;
  assign unused_fwd = ^{ld_addr, valid_q};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4, AW=DW=32). Inputs change 1 time
// unit after a rising edge; outputs are sampled between edges.
module tb_store_buffer;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        drain_en;
  logic        MemWr;
  logic [31:0] dm_addr;
  logic [31:0] dm_in;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q [$];

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .drain_en (drain_en),
    .MemWr    (MemWr),
    .dm_addr  (dm_addr),
    .dm_in    (dm_in),
    .count    (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    step();
    st_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", count); end
    n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", st_ready); end
    n_tests++; if (MemWr !== 1'b0) begin n_fail++; $display("FAIL rst_memwr: got %b exp 0", MemWr); end
    n_tests++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin n_fail++; $display("FAIL rst_ld: got hit=%b data=%0h exp 0/0", ld_hit, ld_data); end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_push_drain;
    drain_en = 1'b0;
    drive_push(32'h08, 32'd45);
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL pd_count1: got %0d exp 1", count); end
    n_tests++; if (MemWr !== 1'b0) begin n_fail++; $display("FAIL pd_hold: got %b exp 0", MemWr); end
    drain_en = 1'b1;
    #1;
    n_tests++; if (MemWr !== 1'b1 || dm_addr !== 32'h08 || dm_in !== 32'd45) begin n_fail++; $display("FAIL pd_write: got %b %0h %0d exp 1 8 45", MemWr, dm_addr, dm_in); end
    step();
    n_tests++; if (count !== 3'd0 || MemWr !== 1'b0) begin n_fail++; $display("FAIL pd_count0: got %0d %b exp 0 0", count, MemWr); end
    // Store into empty buffer with the port free: no same-cycle bypass.
    st_valid = 1'b1;
    st_addr  = 32'h20;
    st_data  = 32'd5;
    #1;
    n_tests++; if (MemWr !== 1'b0) begin n_fail++; $display("FAIL pd_nobypass: got %b exp 0", MemWr); end
    step();
    st_valid = 1'b0;
    #1;
    n_tests++; if (count !== 3'd1 || MemWr !== 1'b1 || dm_addr !== 32'h20 || dm_in !== 32'd5) begin n_fail++; $display("FAIL pd_latency1: got %0d %b %0h %0d exp 1 1 20 5", count, MemWr, dm_addr, dm_in); end
    step();
    drain_en = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL pd_empty: got %0d exp 0", count); end
  endtask

  task automatic test_full;
    logic [63:0] e;
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h30 + 32'(4 * i), 32'd11 + 32'(i));
      exp_q.push_back({32'h30 + 32'(4 * i), 32'd11 + 32'(i)});
    end
    n_tests++; if (count !== 3'd4 || st_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got %0d %b exp 4 0", count, st_ready); end
    drive_push(32'h3C, 32'd99);
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_ignore: got %0d exp 4", count); end
    drain_en = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      n_tests++; if (MemWr !== 1'b1 || {dm_addr, dm_in} !== e) begin n_fail++; $display("FAIL full_order: got %b %0h/%0d exp 1 %0h/%0d", MemWr, dm_addr, dm_in, e[63:32], e[31:0]); end
      step();
    end
    drain_en = 1'b0;
    n_tests++; if (count !== 3'd0 || MemWr !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %0d %b exp 0 0", count, MemWr); end
  endtask

  task automatic test_forwarding;
    drain_en = 1'b0;
    drive_push(32'h10, 32'd7);
    drive_push(32'h10, 32'd9);
    ld_addr = 32'h12;
    #1;
    n_tests++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'd9 : 32'd0)) begin n_fail++; $display("FAIL fwd_young: got %b %0d exp %b %0d", ld_hit, ld_data, FWD, FWD ? 9 : 0); end
    ld_addr = 32'h14;
    #1;
    n_tests++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin n_fail++; $display("FAIL fwd_miss: got %b %0d exp 0 0", ld_hit, ld_data); end
    // The store being pushed this cycle is not visible yet.
    st_valid = 1'b1;
    st_addr  = 32'h14;
    st_data  = 32'd3;
    #1;
    n_tests++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_pushing: got %b exp 0", ld_hit); end
    step();
    st_valid = 1'b0;
    n_tests++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL fwd_pushed: got %b %0d exp %b %0d", ld_hit, ld_data, FWD, FWD ? 3 : 0); end
    // Head entry draining this cycle still participates.
    ld_addr  = 32'h10;
    drain_en = 1'b1;
    #1;
    n_tests++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'd9 : 32'd0) || dm_in !== 32'd7) begin n_fail++; $display("FAIL fwd_drainhead: got %b %0d dm=%0d exp %b %0d dm=7", ld_hit, ld_data, dm_in, FWD, FWD ? 9 : 0); end
    step();
    n_tests++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'd9 : 32'd0) || dm_in !== 32'd9) begin n_fail++; $display("FAIL fwd_after1: got %b %0d dm=%0d exp %b %0d dm=9", ld_hit, ld_data, dm_in, FWD, FWD ? 9 : 0); end
    step();
    n_tests++; if (ld_hit !== 1'b0 || ld_data !== 32'd0 || dm_in !== 32'd3) begin n_fail++; $display("FAIL fwd_gone: got %b %0d dm=%0d exp 0 0 dm=3", ld_hit, ld_data, dm_in); end
    step();
    drain_en = 1'b0;
    ld_addr  = 32'hFFFC;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL fwd_empty: got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    drain_en = 1'b0;
    drive_push(32'h40, 32'd1);
    exp_q.push_back({32'h40, 32'd1});
    drive_push(32'h44, 32'd2);
    exp_q.push_back({32'h44, 32'd2});
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_fill: got %0d exp 2", count); end
    // One simultaneous push/pop, then six more to wrap the pointers.
    for (int i = 0; i < 7; i++) begin
      st_valid = 1'b1;
      st_addr  = 32'h48 + 32'(4 * i);
      st_data  = 32'd3 + 32'(i);
      drain_en = 1'b1;
      exp_q.push_back({32'h48 + 32'(4 * i), 32'd3 + 32'(i)});
      e = exp_q.pop_front();
      #1;
      n_tests++; if (MemWr !== 1'b1 || {dm_addr, dm_in} !== e) begin n_fail++; $display("FAIL b2b_order%0d: got %b %0h/%0d exp 1 %0h/%0d", i, MemWr, dm_addr, dm_in, e[63:32], e[31:0]); end
      step();
      n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count%0d: got %0d exp 2", i, count); end
    end
    st_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      n_tests++; if (MemWr !== 1'b1 || {dm_addr, dm_in} !== e) begin n_fail++; $display("FAIL b2b_tail: got %b %0h/%0d exp 1 %0h/%0d", MemWr, dm_addr, dm_in, e[63:32], e[31:0]); end
      step();
    end
    drain_en = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid;
    drain_en = 1'b0;
    drive_push(32'h60, 32'd21);
    drive_push(32'h64, 32'd22);
    drive_push(32'h68, 32'd23);
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL rm_fill: got %0d exp 3", count); end
    drain_en = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0 || MemWr !== 1'b0 || st_ready !== 1'b1) begin n_fail++; $display("FAIL rm_async: got %0d %b %b exp 0 0 1", count, MemWr, st_ready); end
    step();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (MemWr !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rm_nowrite%0d: got %b %0d exp 0 0", i, MemWr, count); end
    end
    drain_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = 32'hFFFC;
    drain_en = 1'b0;
    test_reset();
    test_push_drain();
    test_full();
    test_forwarding();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
